// File: rtl/fir_decim_cplx.sv
// fir_decim_cplx: complex I/Q FIR low-pass and decimator with one
// time-shared MAC per channel. The filter runs only on retained samples.
// Ports:
//   clock, rst             single clock, synchronous active-high reset
//   in_real/in_imag        baseband I/Q samples (signed DATA_W)
//   in_valid/in_ready      input handshake, transfer on valid && ready
//   coef_we/addr/data      tap load, honoured only while filling
//   out_real/out_imag      filtered, decimated, scaled, saturated I/Q
//   out_valid              one-cycle pulse per new output
module fir_decim_cplx #(
  parameter int DATA_W = 22,
  parameter int COEF_W = 12,
  parameter int TAPS   = 32,
  parameter int DECIM  = 4,
  parameter int OUT_W  = 32,
  parameter int SHIFT  = 0
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic signed [DATA_W-1:0]  in_real,
  input  logic signed [DATA_W-1:0]  in_imag,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_data,
  output logic signed [OUT_W-1:0]   out_real,
  output logic signed [OUT_W-1:0]   out_imag,
  output logic                      out_valid
);

  localparam int AW    = $clog2(TAPS);
  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = PW + $clog2(TAPS);
  localparam int PHW   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int SW    = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

  typedef enum logic [1:0] {
    FILL,
    MAC,
    OUT
  } state_t;

  state_t state;

  logic signed [DATA_W-1:0] x_r [TAPS];
  logic signed [DATA_W-1:0] x_i [TAPS];
  logic signed [COEF_W-1:0] h   [TAPS];

  logic [AW-1:0]           k;
  logic [PHW-1:0]          phase;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] acc_i;

  logic                    xfer;
  logic                    decim_hit;
  logic                    last_tap;
  logic                    coef_ok;
  logic signed [PW-1:0]    p_r;
  logic signed [PW-1:0]    p_i;
  logic signed [ACC_W-1:0] sum_r;
  logic signed [ACC_W-1:0] sum_i;
  logic signed [OUT_W-1:0] sat_r;
  logic signed [OUT_W-1:0] sat_i;

  // Compare in a width wide enough for both the accumulator
  // and the output range so either may be the larger one.
  function automatic logic signed [OUT_W-1:0] sat_fn(
    input logic signed [ACC_W-1:0] a
  );
    logic signed [SW-1:0] v;
    logic signed [SW-1:0] hi;
    logic signed [SW-1:0] lo;
    v  = SW'(a >>> SHIFT);
    hi = SW'({(OUT_W-1){1'b1}});
    lo = ~hi;
    if (v > hi) begin
      return hi[OUT_W-1:0];
    end else if (v < lo) begin
      return lo[OUT_W-1:0];
    end else begin
      return v[OUT_W-1:0];
    end
  endfunction

  assign xfer      = in_valid && in_ready;
  assign decim_hit = (phase == PHW'(DECIM - 1));
  assign last_tap  = (k == AW'(TAPS - 1));
  assign coef_ok   = coef_we && (state == FILL)
                  && (int'(coef_addr) < TAPS);

  assign p_r   = PW'(h[k]) * PW'(x_r[k]);
  assign p_i   = PW'(h[k]) * PW'(x_i[k]);
  assign sum_r = acc_r + ACC_W'(p_r);
  assign sum_i = acc_i + ACC_W'(p_i);
  assign sat_r = sat_fn(sum_r);
  assign sat_i = sat_fn(sum_i);

  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= FILL;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      phase     <= '0;
      k         <= '0;
      acc_r     <= '0;
      acc_i     <= '0;
      for (int n = 0; n < TAPS; n++) begin
        x_r[n] <= '0;
        x_i[n] <= '0;
        h[n]   <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      // Lands on the same edge as a decimating transfer,
      // so the MAC that follows already sees the new tap.
      if (coef_ok) begin
        h[coef_addr] <= coef_data;
      end
      unique case (state)
        FILL: begin
          if (xfer) begin
            for (int n = TAPS - 1; n > 0; n--) begin
              x_r[n] <= x_r[n-1];
              x_i[n] <= x_i[n-1];
            end
            x_r[0] <= in_real;
            x_i[0] <= in_imag;
            if (decim_hit) begin
              phase    <= '0;
              k        <= '0;
              acc_r    <= '0;
              acc_i    <= '0;
              in_ready <= 1'b0;
              state    <= MAC;
            end else begin
              phase <= phase + PHW'(1);
            end
          end
        end
        MAC: begin
          acc_r <= sum_r;
          acc_i <= sum_i;
          k     <= k + AW'(1);
          // Final product is folded straight into the output
          // register so out_valid rises on entry to OUT.
          if (last_tap) begin
            out_real  <= sat_r;
            out_imag  <= sat_i;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          in_ready <= 1'b1;
          state    <= FILL;
        end
        default: begin
          in_ready <= 1'b1;
          state    <= FILL;
        end
      endcase
    end
  end

endmodule
